// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I main control FSM with imem/dmem req/ack timeout.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they execute as NOPs.
module multicycle_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_op,
    output logic [2:0] state_o,
    output logic       bus_err,
    output logic       illegal
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_e           state_q;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    logic             illegal_q;

    logic c_r, c_i, c_ld, c_st, c_br, c_jal, c_jalr;
    logic op_known, wait_cyc, tmo;
    logic       h_alu_src, h_branch;
    logic [1:0] h_m2r, h_alu_op;

    assign c_r    = (op_q == OP_R);
    assign c_i    = (op_q == OP_I);
    assign c_ld   = (op_q == OP_LD);
    assign c_st   = (op_q == OP_ST);
    assign c_br   = (op_q == OP_BR);
    assign c_jal  = (op_q == OP_JAL);
    assign c_jalr = (op_q == OP_JALR);

    assign op_known = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

    // A wait cycle is any FETCH/MEM cycle without the matching ack.
    assign wait_cyc = ((state_q == FETCH) && !imem_ack) ||
                      ((state_q == MEM) && !dmem_ack);
    assign tmo      = wait_cyc && (cnt_q == TMO);

    assign h_alu_src = c_i | c_ld | c_st | c_jalr;
    assign h_branch  = c_br | c_jal | c_jalr;
    assign h_m2r     = c_ld ? 2'b01 : (c_jal | c_jalr) ? 2'b10 : 2'b00;
    assign h_alu_op  = c_r ? 2'b10 : c_br ? 2'b01 :
                       (c_jal | c_jalr) ? 2'b11 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            bus_err_q <= tmo;
            cnt_q     <= (wait_cyc && !tmo) ? cnt_q + 1'b1 : '0;
            case (state_q)
                FETCH: if (imem_ack) state_q <= DECODE;
                DECODE: begin
                    op_q    <= opcode;
                    state_q <= EXEC;
`ifdef ILLEGAL_TRAP_EN
                    if (!op_known) begin
                        state_q   <= TRAP;
                        illegal_q <= 1'b1;
                    end
`endif
                end
                EXEC: begin
                    if (c_ld || c_st) state_q <= MEM;
                    else if (c_r || c_i || c_jal || c_jalr) state_q <= WB;
                    else state_q <= FETCH;
                end
                MEM: begin
                    if (dmem_ack) state_q <= c_ld ? WB : FETCH;
                    else if (tmo) state_q <= FETCH;
                end
                WB:      state_q <= FETCH;
                TRAP:    state_q <= TRAP;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Everything is gated by rst so requests drop in the reset cycle itself.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_op     = 2'b00;
        state_o    = 3'd0;
        bus_err    = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            state_o = state_q;
            bus_err = bus_err_q;
            illegal = illegal_q || ((state_q == DECODE) && !op_known);
            if (state_q inside {EXEC, MEM, WB}) begin
                alu_src    = h_alu_src;
                branch     = h_branch;
                mem_to_reg = h_m2r;
                alu_op     = h_alu_op;
            end
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                    pc_write = imem_ack;
                end
                EXEC: begin
                    if (c_br) begin
                        pc_write = branch_taken;
                        pc_src   = 2'b01;
                    end else if (c_jal) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end else if (c_jalr) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                end
                MEM: begin
                    dmem_req  = 1'b1;
                    mem_read  = c_ld;
                    mem_write = c_st;
                end
                WB:      reg_write = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random instruction streams checked cycle by cycle
// against a trace model built from the instruction control table.
`timescale 1ns/1ps
module tb_multicycle_control;
    localparam int TMO = 4;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [1:0] P0 = 2'b00;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] I    = 7'b0010011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
    logic       imem_req, dmem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       branch, mem_read, mem_write, alu_src, reg_write;
    logic [1:0] mem_to_reg, alu_op;
    logic [2:0] state_o;
    logic       bus_err, illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .state_o(state_o), .bus_err(bus_err), .illegal(illegal)
    );

    typedef struct packed {
        logic       known, as, rw, mr, mw, br;
        logic [1:0] m2r, aop;
    } row_t;

    function automatic row_t spec_row(input logic [6:0] op);
        row_t r;
        r = '0;
        case (op)
            R:    r = '{Y, N, Y, N, N, N, 2'b00, 2'b10};
            I:    r = '{Y, Y, Y, N, N, N, 2'b00, 2'b00};
            LD:   r = '{Y, Y, Y, Y, N, N, 2'b01, 2'b00};
            ST:   r = '{Y, Y, N, N, Y, N, 2'b00, 2'b00};
            BR:   r = '{Y, N, N, N, N, Y, 2'b00, 2'b01};
            JAL:  r = '{Y, N, Y, N, N, Y, 2'b10, 2'b11};
            JALR: r = '{Y, Y, Y, N, N, Y, 2'b10, 2'b11};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [19:0] ev(
        input logic [2:0] st, input logic ir, dr, iw, pw, input logic [1:0] ps,
        input logic b, mr, mw, as, rw, input logic [1:0] mtr, ao, input logic be, il);
        return {st, ir, dr, iw, pw, ps, b, mr, mw, as, rw, mtr, ao, be, il};
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic step(input logic r, ia, da, bt, input logic [6:0] op,
                        input string tag, input logic [19:0] exp);
        logic [19:0] obs;
        @(posedge clk);
        #1;
        rst = r;
        imem_ack = ia;
        dmem_ack = da;
        branch_taken = bt;
        opcode = op;
        #1;
        obs = {state_o, imem_req, dmem_req, ir_write, pc_write, pc_src, branch,
               mem_read, mem_write, alu_src, reg_write, mem_to_reg, alu_op,
               bus_err, illegal};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction: fetch waits fw cycles, memory waits mw cycles (or times out).
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic bt, input logic mto);
        row_t w;
        logic pcw;
        logic [1:0] pcs;
        int nm;
        w = spec_row(op);
        for (int k = 0; k <= fw; k++)
            step(N, (k == fw), N, rb(), rop(), "fetch",
                 ev(S_F, Y, N, (k == fw), (k == fw), P0, N, N, N, N, N, P0, P0, N, N));
        step(N, N, N, rb(), op, "decode",
             ev(S_D, N, N, N, N, P0, N, N, N, N, N, P0, P0, N, !w.known));
        if (!w.known) begin
`ifdef ILLEGAL_TRAP_EN
            for (int k = 0; k < 3; k++)
                step(N, rb(), rb(), rb(), rop(), "trap",
                     ev(S_T, N, N, N, N, P0, N, N, N, N, N, P0, P0, N, Y));
            step(Y, N, N, N, rop(), "trap_rst", '0);
`else
            step(N, N, N, rb(), rop(), "nop_exec",
                 ev(S_E, N, N, N, N, P0, N, N, N, N, N, P0, P0, N, N));
`endif
            return;
        end
        pcw = (op == BR) ? bt : ((op == JAL) || (op == JALR));
        pcs = (op == JALR) ? 2'b10 : ((op == BR) || (op == JAL)) ? 2'b01 : 2'b00;
        step(N, N, N, bt, rop(), "exec",
             ev(S_E, N, N, N, pcw, pcs, w.br, N, N, w.as, N, w.m2r, w.aop, N, N));
        if (w.mr || w.mw) begin
            nm = mto ? TMO : mw;
            for (int k = 0; k <= nm; k++)
                step(N, N, (!mto && (k == nm)), rb(), rop(), "mem",
                     ev(S_M, N, Y, N, N, P0, w.br, w.mr, w.mw, w.as, N, w.m2r, w.aop, N, N));
            if (mto) begin
                step(N, N, N, rb(), rop(), "mem_berr",
                     ev(S_F, Y, N, N, N, P0, N, N, N, N, N, P0, P0, Y, N));
                return;
            end
        end
        if (w.rw)
            step(N, N, N, rb(), rop(), "wb",
                 ev(S_W, N, N, N, N, P0, w.br, N, N, w.as, Y, w.m2r, w.aop, N, N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [8];
        ops = '{R, I, LD, ST, BR, JAL, JALR, BAD};

        step(Y, N, N, N, rop(), "reset0", '0);
        step(Y, Y, Y, Y, rop(), "reset1", '0);

        run_instr(R, 0, 0, N, N);
        run_instr(LD, 0, 3, N, N);
        run_instr(BR, 0, 0, Y, N);
        run_instr(BR, 1, 0, N, N);
        run_instr(JALR, 0, 0, N, N);
        run_instr(JAL, 2, 0, N, N);
        run_instr(I, TMO, 0, N, N);

        for (int k = 0; k <= TMO; k++)
            step(N, N, N, rb(), rop(), "fetch_wait",
                 ev(S_F, Y, N, N, N, P0, N, N, N, N, N, P0, P0, N, N));
        step(N, N, N, rb(), rop(), "fetch_berr",
             ev(S_F, Y, N, N, N, P0, N, N, N, N, N, P0, P0, Y, N));
        run_instr(I, 0, 0, N, N);

        run_instr(ST, 0, TMO, N, N);
        run_instr(LD, 0, 0, N, Y);
        run_instr(R, 0, 0, N, N);

        step(N, Y, N, rb(), rop(), "rm_fetch",
             ev(S_F, Y, N, Y, Y, P0, N, N, N, N, N, P0, P0, N, N));
        step(N, N, N, rb(), LD, "rm_decode",
             ev(S_D, N, N, N, N, P0, N, N, N, N, N, P0, P0, N, N));
        step(N, N, N, rb(), rop(), "rm_exec",
             ev(S_E, N, N, N, N, P0, N, N, N, Y, N, 2'b01, P0, N, N));
        for (int k = 0; k < 2; k++)
            step(N, N, N, rb(), rop(), "rm_mem",
                 ev(S_M, N, Y, N, N, P0, N, Y, N, Y, N, 2'b01, P0, N, N));
        step(Y, N, Y, rb(), rop(), "rm_rst", '0);

        run_instr(BAD, 0, 0, N, N);
        run_instr(ST, 1, 1, N, N);

        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? rop() : ops[$urandom_range(0, 7)];
            run_instr(op, int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)),
                      rb(), N);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
